// File: rtl/canyon_dl_rom_arbiter_pkg.sv
// Shared types and widths for the canyon download/ROM-write arbiter.
// Pure declarations; no logic, latency or backpressure of its own.
package canyon_dl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SETTLE,
    ST_RUN
  } state_t;

  localparam int NUM_REGIONS = 4;
  localparam int ADDR_W      = 17;
  localparam int OFS_W       = 13;

  typedef logic [1:0] region_idx_t;

  function automatic logic [NUM_REGIONS-1:0] region_onehot(input region_idx_t idx);
    region_onehot      = '0;
    region_onehot[idx] = 1'b1;
  endfunction

endpackage

// File: rtl/canyon_dl_rom_arbiter_if.sv
// Download stream, secondary requester and ROM write port bundle.
// master = HPS/NVRAM side driving requests, slave = the arbiter.
interface canyon_dl_if;
  import canyon_dl_pkg::*;

  logic                   dn_download;
  logic                   dn_wr;
  logic [ADDR_W-1:0]      dn_addr;
  logic [7:0]             dn_data;
  logic                   nv_req;
  logic [ADDR_W-1:0]      nv_addr;
  logic [7:0]             nv_data;
  logic                   nv_ack;
  logic [NUM_REGIONS-1:0] rom_we;
  logic [OFS_W-1:0]       rom_addr;
  logic [7:0]             rom_data;
  logic                   core_reset;
  logic                   load_done;
  logic                   addr_err;
  logic [ADDR_W-1:0]      byte_count;

  modport master (
    output dn_download, dn_wr, dn_addr, dn_data, nv_req, nv_addr, nv_data,
    input  nv_ack, rom_we, rom_addr, rom_data, core_reset, load_done, addr_err, byte_count
  );

  modport slave (
    input  dn_download, dn_wr, dn_addr, dn_data, nv_req, nv_addr, nv_data,
    output nv_ack, rom_we, rom_addr, rom_data, core_reset, load_done, addr_err, byte_count
  );

endinterface

// File: rtl/canyon_dl_rom_arbiter_region_decode.sv
// Combinational byte address -> {hit, one-hot region, region offset}; lowest index wins.
// Zero latency, no backpressure.
module canyon_dl_region_decode
  import canyon_dl_pkg::*;
#(
  parameter logic [ADDR_W-1:0] R0_BASE = 17'h00000,
  parameter logic [ADDR_W-1:0] R0_SIZE = 17'h00800,
  parameter logic [ADDR_W-1:0] R1_BASE = 17'h00800,
  parameter logic [ADDR_W-1:0] R1_SIZE = 17'h00800,
  parameter logic [ADDR_W-1:0] R2_BASE = 17'h01000,
  parameter logic [ADDR_W-1:0] R2_SIZE = 17'h00200,
  parameter logic [ADDR_W-1:0] R3_BASE = 17'h01200,
  parameter logic [ADDR_W-1:0] R3_SIZE = 17'h00100
) (
  input  logic [ADDR_W-1:0]      addr,
  output logic                   hit,
  output logic [NUM_REGIONS-1:0] we,
  output logic [OFS_W-1:0]       ofs
);

  localparam logic [ADDR_W-1:0] BASE [NUM_REGIONS] = '{R0_BASE, R1_BASE, R2_BASE, R3_BASE};
  localparam logic [ADDR_W-1:0] SIZE [NUM_REGIONS] = '{R0_SIZE, R1_SIZE, R2_SIZE, R3_SIZE};

  region_idx_t idx;

  // Scan high to low so the lowest matching index is the one left standing.
  // Limits are compared one bit wider so BASE+SIZE cannot wrap.
  always_comb begin
    hit = 1'b0;
    idx = '0;
    ofs = '0;
    for (int i = NUM_REGIONS - 1; i >= 0; i--) begin
      if (({1'b0, addr} >= {1'b0, BASE[i]}) &&
          ({1'b0, addr} <  ({1'b0, BASE[i]} + {1'b0, SIZE[i]}))) begin
        hit = 1'b1;
        idx = region_idx_t'(i);
        ofs = OFS_W'(addr - BASE[i]);
      end
    end
    we = hit ? region_onehot(idx) : '0;
  end

endmodule

// File: rtl/canyon_dl_rom_arbiter.sv
// Routes HPS download bytes and low-priority NVRAM restores onto one ROM write port, sequencing core reset.
// Writes appear one cycle after the strobe; nv_req is held until nv_ack and only granted in RUN.
module canyon_dl_rom_arbiter
  import canyon_dl_pkg::*;
#(
  parameter logic [ADDR_W-1:0] R0_BASE     = 17'h00000,
  parameter logic [ADDR_W-1:0] R0_SIZE     = 17'h00800,
  parameter logic [ADDR_W-1:0] R1_BASE     = 17'h00800,
  parameter logic [ADDR_W-1:0] R1_SIZE     = 17'h00800,
  parameter logic [ADDR_W-1:0] R2_BASE     = 17'h01000,
  parameter logic [ADDR_W-1:0] R2_SIZE     = 17'h00200,
  parameter logic [ADDR_W-1:0] R3_BASE     = 17'h01200,
  parameter logic [ADDR_W-1:0] R3_SIZE     = 17'h00100,
  parameter int                HOLD_CYCLES = 1024
) (
  input  logic        clk_sys,
  input  logic        reset,
  canyon_dl_if.slave  bus
);

  localparam logic [15:0] HOLD_M1 = 16'(HOLD_CYCLES - 1);

  state_t                 state_q, state_d;
  logic [15:0]            hold_q, hold_d;
  logic                   dl_prev_q;
  logic [NUM_REGIONS-1:0] rom_we_q, rom_we_d;
  logic [OFS_W-1:0]       rom_addr_q, rom_addr_d;
  logic [7:0]             rom_data_q, rom_data_d;
  logic                   nv_ack_q, nv_ack_d;
  logic                   nv_block_q, nv_block_d;
  logic                   core_reset_q, core_reset_d;
  logic                   load_done_q, load_done_d;
  logic                   addr_err_q, addr_err_d;
  logic [ADDR_W-1:0]      byte_count_q, byte_count_d;

  logic                   dn_hit, nv_hit;
  logic [NUM_REGIONS-1:0] dn_we, nv_we;
  logic [OFS_W-1:0]       dn_ofs, nv_ofs;
  logic                   dl_rise, dl_fall, load_entry, dn_acc, nv_grant;

  canyon_dl_region_decode #(
    .R0_BASE(R0_BASE), .R0_SIZE(R0_SIZE), .R1_BASE(R1_BASE), .R1_SIZE(R1_SIZE),
    .R2_BASE(R2_BASE), .R2_SIZE(R2_SIZE), .R3_BASE(R3_BASE), .R3_SIZE(R3_SIZE)
  ) u_dn_dec (
    .addr(bus.dn_addr), .hit(dn_hit), .we(dn_we), .ofs(dn_ofs)
  );

  canyon_dl_region_decode #(
    .R0_BASE(R0_BASE), .R0_SIZE(R0_SIZE), .R1_BASE(R1_BASE), .R1_SIZE(R1_SIZE),
    .R2_BASE(R2_BASE), .R2_SIZE(R2_SIZE), .R3_BASE(R3_BASE), .R3_SIZE(R3_SIZE)
  ) u_nv_dec (
    .addr(bus.nv_addr), .hit(nv_hit), .we(nv_we), .ofs(nv_ofs)
  );

  always_comb begin
    dl_rise = bus.dn_download & ~dl_prev_q;
    dl_fall = ~bus.dn_download & dl_prev_q;
    state_d = state_q;
    hold_d  = hold_q;
    case (state_q)
      ST_IDLE:   if (dl_rise) state_d = ST_LOAD;
      ST_LOAD:   if (dl_fall) begin
                   state_d = ST_SETTLE;
                   hold_d  = HOLD_M1;
                 end
      ST_SETTLE: if (dl_rise)           state_d = ST_LOAD;
                 else if (hold_q == '0) state_d = ST_RUN;
                 else                   hold_d  = hold_q - 16'd1;
      ST_RUN:    if (dl_rise) state_d = ST_LOAD;
      default:   state_d = ST_IDLE;
    endcase

    load_entry = (state_d == ST_LOAD) && (state_q != ST_LOAD);
    dn_acc     = (state_q == ST_LOAD) && bus.dn_wr;
    // A grant in the cycle RUN is being left would land its write inside the new load.
    nv_grant   = (state_q == ST_RUN) && !dl_rise && bus.nv_req && !bus.dn_wr && !nv_block_q;

    rom_we_d     = '0;
    rom_addr_d   = rom_addr_q;
    rom_data_d   = rom_data_q;
    nv_ack_d     = nv_grant;
    nv_block_d   = nv_grant | (nv_block_q & bus.nv_req);
    byte_count_d = load_entry ? '0 : byte_count_q;
    addr_err_d   = load_entry ? 1'b0 : addr_err_q;

    if (dn_acc) begin
      if (dn_hit) begin
        rom_we_d   = dn_we;
        rom_addr_d = dn_ofs;
        rom_data_d = bus.dn_data;
        if (byte_count_q != '1) byte_count_d = byte_count_q + 1'b1;
      end else begin
        addr_err_d = 1'b1;
      end
    end else if (nv_grant) begin
      if (nv_hit) begin
        rom_we_d   = nv_we;
        rom_addr_d = nv_ofs;
        rom_data_d = bus.nv_data;
      end else begin
        addr_err_d = 1'b1;
      end
    end

    core_reset_d = (state_d != ST_RUN);
    case (state_d)
      ST_LOAD: load_done_d = 1'b0;
      ST_RUN:  load_done_d = 1'b1;
      default: load_done_d = load_done_q;
    endcase
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      hold_q       <= '0;
      dl_prev_q    <= 1'b0;
      rom_we_q     <= '0;
      rom_addr_q   <= '0;
      rom_data_q   <= '0;
      nv_ack_q     <= 1'b0;
      nv_block_q   <= 1'b0;
      core_reset_q <= 1'b1;
      load_done_q  <= 1'b0;
      addr_err_q   <= 1'b0;
      byte_count_q <= '0;
    end else begin
      state_q      <= state_d;
      hold_q       <= hold_d;
      dl_prev_q    <= bus.dn_download;
      rom_we_q     <= rom_we_d;
      rom_addr_q   <= rom_addr_d;
      rom_data_q   <= rom_data_d;
      nv_ack_q     <= nv_ack_d;
      nv_block_q   <= nv_block_d;
      core_reset_q <= core_reset_d;
      load_done_q  <= load_done_d;
      addr_err_q   <= addr_err_d;
      byte_count_q <= byte_count_d;
    end
  end

  assign bus.rom_we     = rom_we_q;
  assign bus.rom_addr   = rom_addr_q;
  assign bus.rom_data   = rom_data_q;
  assign bus.nv_ack     = nv_ack_q;
  assign bus.core_reset = core_reset_q;
  assign bus.load_done  = load_done_q;
  assign bus.addr_err   = addr_err_q;
  assign bus.byte_count = byte_count_q;

endmodule

// File: tb/tb_canyon_dl_rom_arbiter.sv
// Randomized scoreboard bench for canyon_dl_rom_arbiter: drivers push expected ROM writes,
// a negedge monitor pops and compares them whenever the DUT writes or acks.
module tb_canyon_dl_rom_arbiter;
  import canyon_dl_pkg::*;

  localparam int H = 1024;

  logic clk_sys = 1'b0;
  logic reset   = 1'b1;
  canyon_dl_if dif();

  canyon_dl_rom_arbiter #(.HOLD_CYCLES(H)) dut (
    .clk_sys (clk_sys),
    .reset   (reset),
    .bus     (dif)
  );

  always #5 clk_sys = ~clk_sys;

  int cyc = 0;
  always @(posedge clk_sys) cyc++;

  typedef struct {
    int         cyc;
    logic [3:0] we;
    logic [12:0] ofs;
    logic [7:0] data;
    logic       ack;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int checks = 0;
  int errors = 0;

  typedef enum {M_IDLE, M_LOAD, M_SETTLE, M_RUN} mmode_t;
  mmode_t mode = M_IDLE;
  int     m_bytes = 0;
  bit     m_err = 1'b0;

  int RB[4] = '{'h00000, 'h00800, 'h01000, 'h01200};
  int RS[4] = '{'h00800, 'h00800, 'h00200, 'h00100};

  bit         p_hit;
  logic [3:0] p_we;
  logic [12:0] p_ofs;
  logic [7:0] p_data;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic void ref_decode(input int a, output bit hit, output logic [3:0] we,
                                     output logic [12:0] ofs);
    hit = 1'b0; we = '0; ofs = '0;
    for (int i = 0; i < 4; i++)
      if (!hit && a >= RB[i] && a < RB[i] + RS[i]) begin
        hit = 1'b1;
        we  = 4'(1 << i);
        ofs = 13'(a - RB[i]);
      end
  endfunction

  function automatic int rand_addr();
    int r;
    r = $urandom_range(0, 3);
    if ($urandom_range(0, 7) == 7) return $urandom_range('h1300, 'h1FFFF);
    return RB[r] + $urandom_range(0, RS[r] - 1);
  endfunction

  // Scoreboard monitor
  always @(negedge clk_sys) begin
    if (!reset) begin
      while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
        mon_e = exp_q.pop_front();
        checks++; errors++;
        $display("FAIL missing_write: expected we=%b ack=%b at cycle %0d, nothing seen by %0d",
                 mon_e.we, mon_e.ack, mon_e.cyc, cyc);
      end
      if (dif.rom_we != 4'b0 || dif.nv_ack) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_write: got we=%b ack=%b at cycle %0d, expected none",
                   dif.rom_we, dif.nv_ack, cyc);
        end else begin
          mon_e = exp_q.pop_front();
          chk("write_cycle", cyc, mon_e.cyc);
          chk("rom_we", dif.rom_we, mon_e.we);
          chk("nv_ack", dif.nv_ack, mon_e.ack);
          if (mon_e.we != 4'b0) begin
            chk("rom_addr", dif.rom_addr, mon_e.ofs);
            chk("rom_data", dif.rom_data, mon_e.data);
          end
        end
      end
    end
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_rom_we"}, dif.rom_we, 0);
    chk({tag, "_rom_addr"}, dif.rom_addr, 0);
    chk({tag, "_rom_data"}, dif.rom_data, 0);
    chk({tag, "_nv_ack"}, dif.nv_ack, 0);
    chk({tag, "_core_reset"}, dif.core_reset, 1);
    chk({tag, "_load_done"}, dif.load_done, 0);
    chk({tag, "_addr_err"}, dif.addr_err, 0);
    chk({tag, "_byte_count"}, dif.byte_count, 0);
  endtask

  task automatic dl_start();
    dif.dn_download = 1'b1;
    tick();
    mode = M_LOAD; m_bytes = 0; m_err = 1'b0;
    chk("load_core_reset", dif.core_reset, 1);
    chk("load_load_done", dif.load_done, 0);
    chk("load_byte_count", dif.byte_count, 0);
    chk("load_addr_err", dif.addr_err, 0);
  endtask

  task automatic dl_byte(input int a, input logic [7:0] d);
    bit hit; logic [3:0] we; logic [12:0] ofs;
    dif.dn_wr = 1'b1; dif.dn_addr = 17'(a); dif.dn_data = d;
    if (mode == M_LOAD) begin
      ref_decode(a, hit, we, ofs);
      if (hit) begin
        exp_q.push_back(exp_t'{cyc + 1, we, ofs, d, 1'b0});
        if (m_bytes < 'h1FFFF) m_bytes++;
      end else m_err = 1'b1;
    end
    tick();
    dif.dn_wr = 1'b0;
  endtask

  task automatic dl_end(input bit pending);
    int k, n;
    dif.dn_download = 1'b0;
    k = cyc;
    mode = M_SETTLE;
    if (pending)
      exp_q.push_back(exp_t'{k + H + 2, p_hit ? p_we : 4'b0, p_ofs, p_data, 1'b1});
    n = 0;
    do begin
      tick();
      n++;
    end while (dif.core_reset && n < H + 10);
    mode = M_RUN;
    chk("core_reset_fall_latency", n, H + 1);
    chk("run_load_done", dif.load_done, 1);
    chk("run_byte_count", dif.byte_count, m_bytes);
    chk("run_addr_err", dif.addr_err, m_err);
    if (pending) begin
      if (!p_hit) m_err = 1'b1;
      tick();
      chk("nv_pending_ack", dif.nv_ack, 1);
      tick();
      dif.nv_req = 1'b0;
      tick();
    end
  endtask

  task automatic nv_raise(input int a, input logic [7:0] d);
    ref_decode(a, p_hit, p_we, p_ofs);
    p_data = d;
    dif.nv_req = 1'b1; dif.nv_addr = 17'(a); dif.nv_data = d;
  endtask

  task automatic nv_write(input int a, input logic [7:0] d);
    bit hit; logic [3:0] we; logic [12:0] ofs; int n;
    ref_decode(a, hit, we, ofs);
    dif.nv_req = 1'b1; dif.nv_addr = 17'(a); dif.nv_data = d;
    exp_q.push_back(exp_t'{cyc + 1, hit ? we : 4'b0, ofs, d, 1'b1});
    if (!hit) m_err = 1'b1;
    n = 0;
    do begin
      tick();
      n++;
    end while (!dif.nv_ack && n < 20);
    chk("nv_ack_latency", n, 1);
    // Held one extra cycle: a second grant here would be an unexpected write.
    tick();
    dif.nv_req = 1'b0;
    tick();
    chk("nv_addr_err", dif.addr_err, m_err);
  endtask

  initial begin
    dif.dn_download = 1'b0; dif.dn_wr = 1'b0; dif.dn_addr = '0; dif.dn_data = '0;
    dif.nv_req = 1'b0; dif.nv_addr = '0; dif.nv_data = '0;
    repeat (2) @(posedge clk_sys);
    #1;
    check_reset_vals("por");
    reset = 1'b0;
    tick();
    chk("idle_core_reset", dif.core_reset, 1);

    // First load: 16 bytes into region 0
    dl_start();
    for (int i = 0; i < 16; i++) dl_byte(i, 8'($urandom));
    chk("bc16", dif.byte_count, 16);
    dl_end(1'b0);
    nv_write('h1005, 8'hA5);
    nv_write('h1F000, 8'h3C);
    chk("nv_miss_err", dif.addr_err, 1);
    dl_byte('h0004, 8'h11);
    chk("run_dnwr_ignored_bc", dif.byte_count, 16);

    // Re-download from RUN: region edges, a miss, secondary request parked in LOAD
    dl_start();
    dl_byte('h0800, 8'h01);
    dl_byte('h1000, 8'h02);
    dl_byte('h1200, 8'h03);
    dl_byte('h12FF, 8'h04);
    dl_byte('h1300, 8'h05);
    chk("miss_addr_err", dif.addr_err, 1);
    chk("miss_byte_count", dif.byte_count, 4);
    nv_raise('h1005, 8'hA5);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("nv_no_ack_in_load", dif.nv_ack, 0);
    end
    dl_byte('h07FF, 8'h06);
    chk("err_sticky", dif.addr_err, 1);
    dl_end(1'b1);

    // Rising download during SETTLE returns to LOAD without releasing core reset
    dl_start();
    for (int i = 0; i < 3; i++) dl_byte(rand_addr(), 8'($urandom));
    dif.dn_download = 1'b0;
    mode = M_SETTLE;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("settle_core_reset", dif.core_reset, 1);
    end
    dl_byte('h0010, 8'h77);
    dl_start();
    for (int i = 0; i < 6; i++) dl_byte(rand_addr(), 8'($urandom));
    dl_end(1'b0);

    // Randomized loads followed by secondary restores
    for (int l = 0; l < 3; l++) begin
      dl_start();
      for (int i = 0; i < 24; i++) begin
        dl_byte(rand_addr(), 8'($urandom));
        repeat ($urandom_range(0, 2)) tick();
      end
      dl_end(1'b0);
      for (int i = 0; i < 4; i++) nv_write(rand_addr(), 8'($urandom));
    end

    // Async reset in the middle of a load
    dl_start();
    for (int i = 0; i < 5; i++) dl_byte(rand_addr(), 8'($urandom));
    tick();
    tick();
    reset = 1'b1;
    #1;
    check_reset_vals("mid_load_rst");
    dif.dn_download = 1'b0;
    mode = M_IDLE; m_bytes = 0; m_err = 1'b0;
    tick();
    reset = 1'b0;
    for (int i = 0; i < 3; i++) dl_byte('h0020 + i, 8'($urandom));
    tick();
    chk("post_rst_load_done", dif.load_done, 0);
    chk("post_rst_core_reset", dif.core_reset, 1);
    dl_start();
    for (int i = 0; i < 8; i++) dl_byte(rand_addr(), 8'($urandom));
    dl_end(1'b0);

    repeat (5) tick();
    chk("scoreboard_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/canyon_dl_rom_arbiter.md
Name: canyon_dl_rom_arbiter

Overview:
- Sits between the HPS download stream and the game core's loadable ROM/PROM write ports.
- Decodes each downloaded byte into one of four ROM regions and sequences core reset around a download (IDLE/LOAD/SETTLE/RUN).
- Shares the same ROM write port with a secondary low-priority requester (NVRAM/high-score restore), granting it only while the core runs.
- Replaces the ad-hoc "reset while ioctl_download" OR term at the top level.

Parameters:
- R0_BASE, 17'h00000, start address of region 0 (program ROM low)
- R0_SIZE, 17'h00800, byte size of region 0
- R1_BASE, 17'h00800, start of region 1 (program ROM high)
- R1_SIZE, 17'h00800, size of region 1
- R2_BASE, 17'h01000, start of region 2 (playfield/char ROM)
- R2_SIZE, 17'h00200, size of region 2
- R3_BASE, 17'h01200, start of region 3 (sync/timing PROM)
- R3_SIZE, 17'h00100, size of region 3
- HOLD_CYCLES, 1024, clk_sys cycles core reset stays asserted after download ends (1..65535)

Ports:
- clk_sys  in  1  system clock (12 MHz)
- reset  in  1  asynchronous, active-high reset
- dn_download  in  1  HPS download active level
- dn_wr  in  1  download byte strobe, one cycle per byte
- dn_addr  in  17  download byte address
- dn_data  in  8  download byte
- nv_req  in  1  secondary requester write request, level, held until ack
- nv_addr  in  17  secondary write address, same map as dn_addr
- nv_data  in  8  secondary write byte
- nv_ack  out  1  one-cycle pulse: secondary write issued
- rom_we  out  4  one-hot region write enable
- rom_addr  out  13  byte offset within the selected region
- rom_data  out  8  write data
- core_reset  out  1  active-high reset to game core
- load_done  out  1  high once at least one download completed and HOLD elapsed
- addr_err  out  1  sticky: a write hit no region
- byte_count  out  17  accepted download bytes in the current/last load, saturating at 17'h1FFFF

Behaviour:
- Reset values: state IDLE, core_reset=1, rom_we=0, rom_addr=0, rom_data=0, nv_ack=0, load_done=0, addr_err=0, byte_count=0, hold counter=0.
- dn_download is used directly (already in clk_sys domain); edge detection uses one registered copy.
- IDLE: core_reset=1. Rising dn_download -> LOAD.
- LOAD: core_reset=1, load_done=0. Entry clears byte_count and addr_err. Falling dn_download -> SETTLE with hold counter loaded to HOLD_CYCLES-1.
- SETTLE: core_reset=1; the counter decrements each cycle; at 0 -> RUN. Rising dn_download in SETTLE -> LOAD (counter abandoned).
- RUN: core_reset=0, load_done=1. Rising dn_download -> LOAD; core_reset asserts on the next edge.
- Write path is fully registered with 1-cycle latency: a strobe at edge N drives rom_we/rom_addr/rom_data during cycle N+1 for exactly one cycle.
- Decode: region i hits when BASE_i <= addr < BASE_i+SIZE_i. Lowest index wins on overlap. rom_addr = (addr-BASE_i)[12:0].
- A miss drives rom_we=0, sets addr_err, and does not increment byte_count.
- Download writes accepted only in LOAD. dn_wr in IDLE/SETTLE/RUN is ignored, with no error.
- Secondary writes are granted only in RUN, and only in a cycle with no download write. The grant issues the write and pulses nv_ack in the same cycle rom_we is asserted (nv_req sampled at N -> ack at N+1).
- A secondary miss pulses nv_ack, writes nothing and sets addr_err.
- After an ack, nv_req must drop for one cycle before a new grant (no back-to-back double grant on a held request). A request pending when leaving RUN stays unacked until the next RUN.
- Simultaneous dn_wr and nv_req: download wins; nv_req waits.
- Async reset mid-LOAD: all state returns to reset values; the partial image is not flagged, and load_done stays 0 until a full new download completes.

Decomposition:
- Package canyon_dl_pkg: state enum (ST_IDLE, ST_LOAD, ST_SETTLE, ST_RUN), NUM_REGIONS=4, ADDR_W=17, OFS_W=13, region index type.
- Sub-module canyon_dl_region_decode: combinational address -> {hit, one-hot region, offset}, instantiated once per requester path.

Test Plan:
- Reset, dn_download 0->1, 16 bytes at 0x0000..0x000F, dn_download ->0 -> rom_we=4'b0001 each cycle after dn_wr, rom_addr 0..15, byte_count=16; core_reset falls exactly HOLD_CYCLES+1 cycles after the falling edge; load_done=1.
- Download bytes at 0x0800, 0x1000, 0x1200, 0x12FF -> rom_we 0010/0100/1000/1000, rom_addr 0x000/0x000/0x000/0x0FF.
- Download byte at 0x1300 -> rom_we=0, addr_err=1 and stays 1 until the next LOAD entry; byte_count unchanged.
- In RUN: nv_req with addr 0x1005, data 0xA5 -> next cycle rom_we=0100, rom_addr=0x005, rom_data=0xA5, nv_ack=1 for one cycle. nv_req during LOAD -> no ack until RUN.
- Re-download from RUN: rising dn_download -> core_reset=1 next cycle, load_done=0, byte_count cleared. dn_download re-rises during SETTLE -> back to LOAD, core_reset never drops.
- Assert reset mid-LOAD after 5 bytes -> all outputs at reset values immediately; state IDLE; no rom_we until a new rising dn_download.
